// File: rtl/pisca_pkg.sv
// Shared widths, saturated-result payload and the saturation helper for the
// triangle-area engine.
package pisca_pkg;

  localparam int unsigned XW       = 9;
  localparam int unsigned YW       = 7;
  localparam int unsigned OUT_W    = 14;
  localparam int unsigned PROD_W   = XW + YW;
  localparam int unsigned SUM_W    = PROD_W + 2;
  localparam int unsigned DIFF_W   = SUM_W + 1;
  localparam int unsigned AREA_MAX = (32'd1 << OUT_W) - 32'd1;

  typedef struct packed {
    logic             ovf;
    logic [OUT_W-1:0] area;
  } sat_t;

  // Clamp an 18-bit magnitude to the display width, flagging overflow.
  function automatic sat_t saturate(input logic [SUM_W-1:0] mag);
    sat_t r;
    if (mag > SUM_W'(AREA_MAX)) begin
      r.area = '1;
      r.ovf  = 1'b1;
    end else begin
      r.area = mag[OUT_W-1:0];
      r.ovf  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/shoelace_sum.sv
// Two-stage sum of three products: registered products, then registered sum.
// Used once per shoelace diagonal direction with permuted operands.
module shoelace_sum
  import pisca_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XW-1:0]     x0,
  input  logic [YW-1:0]     y0,
  input  logic [XW-1:0]     x1,
  input  logic [YW-1:0]     y1,
  input  logic [XW-1:0]     x2,
  input  logic [YW-1:0]     y2,
  output logic [SUM_W-1:0]  sum
);

  logic [PROD_W-1:0] p0, p1, p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      p0  <= '0;
      p1  <= '0;
      p2  <= '0;
      sum <= '0;
    end else begin
      p0  <= PROD_W'(x0) * PROD_W'(y0);
      p1  <= PROD_W'(x1) * PROD_W'(y1);
      p2  <= PROD_W'(x2) * PROD_W'(y2);
      sum <= SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2);
    end
  end

endmodule

// File: rtl/pisca_leds_1.sv
// Pipelined doubled-triangle-area engine: input registers, two shoelace sums,
// then |Sa - Sb| saturated to the LED/display width. Latency 3 after sampling.
module pisca_leds_1
  import pisca_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [XW-1:0]    ax,
  input  logic [YW-1:0]    ay,
  input  logic [XW-1:0]    bx,
  input  logic [YW-1:0]    by,
  input  logic [XW-1:0]    cx,
  input  logic [YW-1:0]    cy,
  output logic [OUT_W-1:0] area,
  output logic             ovf,
  output logic             out_valid
);

  logic [XW-1:0]     ax_q, bx_q, cx_q;
  logic [YW-1:0]     ay_q, by_q, cy_q;
  logic [SUM_W-1:0]  sa, sb;
  logic [DIFF_W-1:0] diff_c;
  logic [SUM_W-1:0]  mag_c;
  sat_t              sat_c;
  logic [2:0]        vld;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ax_q <= '0;
      ay_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      ax_q <= ax;
      ay_q <= ay;
      bx_q <= bx;
      by_q <= by;
      cx_q <= cx;
      cy_q <= cy;
    end
  end

  // Sa = ax*by + ay*cx + bx*cy
  shoelace_sum u_sa (
    .clk   (CLOCK_50),
    .reset (reset),
    .x0    (ax_q),
    .y0    (by_q),
    .x1    (cx_q),
    .y1    (ay_q),
    .x2    (bx_q),
    .y2    (cy_q),
    .sum   (sa)
  );

  // Sb = ay*bx + ax*cy + by*cx
  shoelace_sum u_sb (
    .clk   (CLOCK_50),
    .reset (reset),
    .x0    (bx_q),
    .y0    (ay_q),
    .x1    (ax_q),
    .y1    (cy_q),
    .x2    (cx_q),
    .y2    (by_q),
    .sum   (sb)
  );

  // Signed difference fits in DIFF_W, so the magnitude never wraps in SUM_W.
  always_comb begin
    diff_c = DIFF_W'(sa) - DIFF_W'(sb);
    mag_c  = SUM_W'(diff_c[DIFF_W-1] ? (DIFF_W'(0) - diff_c) : diff_c);
    sat_c  = saturate(mag_c);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      area <= '0;
      ovf  <= 1'b0;
      vld  <= '0;
    end else begin
      area <= sat_c.area;
      ovf  <= sat_c.ovf;
      vld  <= {vld[1:0], 1'b1};
    end
  end

  assign out_valid = vld[2];

endmodule

// File: tb/tb_pisca_leds_1.sv
// Directed bench for the triangle-area engine: hand-computed vectors, a
// randomised stream against a reference model, and a mid-stream reset.
module tb_pisca_leds_1;
  import pisca_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [XW-1:0]    ax, bx, cx;
  logic [YW-1:0]    ay, by, cy;
  logic [OUT_W-1:0] area;
  logic             ovf;
  logic             out_valid;

  int errors = 0;
  int checks = 0;
  int vec [20][6];

  pisca_leds_1 dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .ax        (ax),
    .ay        (ay),
    .bx        (bx),
    .by        (by),
    .cx        (cx),
    .cy        (cy),
    .area      (area),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int axv, input int ayv, input int bxv,
                       input int byv, input int cxv, input int cyv);
    ax = XW'(axv);
    ay = YW'(ayv);
    bx = XW'(bxv);
    by = YW'(byv);
    cx = XW'(cxv);
    cy = YW'(cyv);
  endtask

  task automatic expect_out(input string tag, input int exp_area,
                            input logic exp_ovf, input logic exp_valid);
    checks++;
    assert (area === OUT_W'(exp_area) && ovf === exp_ovf && out_valid === exp_valid)
    else begin
      errors++;
      $error("FAIL %s: area=%0d ovf=%0b valid=%0b, expected area=%0d ovf=%0b valid=%0b",
             tag, area, ovf, out_valid, exp_area, exp_ovf, exp_valid);
    end
  endtask

  function automatic void model(input int axv, input int ayv, input int bxv,
                                input int byv, input int cxv, input int cyv,
                                output int exp_area, output logic exp_ovf);
    int sa, sb, m;
    sa = axv * byv + ayv * cxv + bxv * cyv;
    sb = ayv * bxv + axv * cyv + byv * cxv;
    m  = (sa > sb) ? sa - sb : sb - sa;
    exp_ovf  = (m > 16383);
    exp_area = exp_ovf ? 16383 : m;
  endfunction

  initial begin
    int   ea;
    logic eo;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step(2);
    expect_out("reset_state", 0, 1'b0, 1'b0);

    // Release with A(1,5) B(15,25) C(3,50): valid on 3rd edge, data on 4th
    reset = 1'b0;
    drive(1, 5, 15, 25, 3, 50);
    step(1);
    expect_out("post_reset_e1", 0, 1'b0, 1'b0);
    step(1);
    expect_out("post_reset_e2", 0, 1'b0, 1'b0);
    step(1);
    expect_out("post_reset_e3", 0, 1'b0, 1'b1);
    step(1);
    expect_out("ccw_590", 590, 1'b0, 1'b1);
    step(1);
    expect_out("hold_590", 590, 1'b0, 1'b1);

    drive(1, 5, 3, 50, 15, 25);
    step(4);
    expect_out("cw_swap_590", 590, 1'b0, 1'b1);

    drive(0, 0, 10, 10, 20, 20);
    step(3);
    expect_out("latency_old_590", 590, 1'b0, 1'b1);
    step(1);
    expect_out("collinear_0", 0, 1'b0, 1'b1);

    drive(511, 127, 511, 127, 511, 127);
    step(4);
    expect_out("coincident_0", 0, 1'b0, 1'b1);

    drive(0, 0, 511, 0, 0, 127);
    step(4);
    expect_out("sat_64897", 16383, 1'b1, 1'b1);

    drive(0, 0, 128, 0, 0, 127);
    step(4);
    expect_out("nosat_16256", 16256, 1'b0, 1'b1);

    drive(0, 0, 129, 0, 0, 127);
    step(4);
    expect_out("edge_16383", 16383, 1'b0, 1'b1);

    drive(0, 0, 256, 0, 0, 64);
    step(4);
    expect_out("edge_16384", 16383, 1'b1, 1'b1);

    drive(1, 82, 47, 1, 47, 37);
    step(4);
    expect_out("mixed_1656", 1656, 1'b0, 1'b1);

    // Fresh vector every clock; output trails the sampled vector by 3 clocks
    for (int i = 0; i < 20; i++) begin
      vec[i][0] = int'($urandom_range(511));
      vec[i][1] = int'($urandom_range(127));
      vec[i][2] = int'($urandom_range(511));
      vec[i][3] = int'($urandom_range(127));
      vec[i][4] = int'($urandom_range(511));
      vec[i][5] = int'($urandom_range(127));
    end
    for (int i = 0; i < 23; i++) begin
      if (i < 20)
        drive(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5]);
      step(1);
      if (i >= 3) begin
        model(vec[i-3][0], vec[i-3][1], vec[i-3][2],
              vec[i-3][3], vec[i-3][4], vec[i-3][5], ea, eo);
        expect_out($sformatf("stream_%0d", i - 3), ea, eo, 1'b1);
      end
    end

    // One-clock reset mid-stream flushes everything
    drive(1, 5, 15, 25, 3, 50);
    reset = 1'b1;
    step(1);
    expect_out("mid_reset", 0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1);
    expect_out("flush_e1", 0, 1'b0, 1'b0);
    step(1);
    expect_out("flush_e2", 0, 1'b0, 1'b0);
    step(1);
    expect_out("flush_e3", 0, 1'b0, 1'b1);
    step(1);
    expect_out("flush_data", 590, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
